// File: rtl/gray_tracker_if.sv
// Sample/status bundle between a Gray-code sample source and gray_tracker.
interface gray_tracker_if #(
    parameter int WIDTH = 3,
    parameter int CNT_W = 4
);
    logic             Valid;
    logic [WIDTH-1:0] Gray;
    logic             Clear;
    logic [WIDTH-1:0] Bin;
    logic             Bin_Valid;
    logic             Step_Err;
    logic             Err_Sticky;
    logic [CNT_W-1:0] Wrap_Cnt;
    logic             Overflow;

    modport master (
        output Valid, Gray, Clear,
        input  Bin, Bin_Valid, Step_Err, Err_Sticky, Wrap_Cnt, Overflow
    );

    modport slave (
        input  Valid, Gray, Clear,
        output Bin, Bin_Valid, Step_Err, Err_Sticky, Wrap_Cnt, Overflow
    );
endinterface

// File: rtl/gray_tracker.sv
// Gray-code sample tracker: decodes samples, checks single-step advances, counts wraps.
// Define GRAY_DIR_DOWN_EN to also accept single downward steps.
module gray_tracker #(
    parameter int WIDTH = 3,
    parameter int CNT_W = 4
) (
    input logic          Clk,
    input logic          Reset,
    gray_tracker_if.slave bus
);
    localparam logic [1:0] ST_EMPTY  = 2'd0;
    localparam logic [1:0] ST_LOCKED = 2'd1;
    localparam logic [1:0] ST_FAULT  = 2'd2;

    localparam logic [WIDTH-1:0] MAX = '1;

    function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
        logic [WIDTH-1:0] b;
        b[WIDTH-1] = g[WIDTH-1];
        for (int i = WIDTH - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (c == '1) ? c : CNT_W'(c + 1'b1);
    endfunction

`ifdef GRAY_DIR_DOWN_EN
    function automatic logic [CNT_W-1:0] sat_dec(input logic [CNT_W-1:0] c);
        return (c == '0) ? c : CNT_W'(c - 1'b1);
    endfunction
`endif

    logic [1:0]       state;
    logic [WIDTH-1:0] bin_p1;
    logic             bin_vld_p1;
    logic             step_err_p1;
    logic             err_sticky;
    logic [CNT_W-1:0] wrap_cnt;
    logic             overflow;

    logic [WIDTH-1:0] d_p0;
    logic [WIDTH-1:0] p_inc;
    assign d_p0  = gray2bin(bus.Gray);
    assign p_inc = WIDTH'(bin_p1 + 1'b1);
`ifdef GRAY_DIR_DOWN_EN
    logic [WIDTH-1:0] p_dec;
    assign p_dec = WIDTH'(bin_p1 - 1'b1);
`endif

    // Stage p0 -> p1: classify the decoded sample against the last accepted value
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state       <= ST_EMPTY;
            bin_p1      <= '0;
            bin_vld_p1  <= 1'b0;
            step_err_p1 <= 1'b0;
            err_sticky  <= 1'b0;
            wrap_cnt    <= '0;
            overflow    <= 1'b0;
        end else begin
            step_err_p1 <= 1'b0;
            if (bus.Clear) begin
                state      <= ST_EMPTY;
                err_sticky <= 1'b0;
                bin_vld_p1 <= 1'b0;
            end else if (bus.Valid) begin
                case (state)
                    ST_EMPTY: begin
                        bin_p1     <= d_p0;
                        bin_vld_p1 <= 1'b1;
                        state      <= ST_LOCKED;
                    end
                    ST_LOCKED: begin
                        if (d_p0 == p_inc) begin
                            bin_p1 <= d_p0;
                            if (bin_p1 == MAX) begin
                                wrap_cnt <= sat_inc(wrap_cnt);
                                overflow <= 1'b1;
                            end
                        end else if (d_p0 == bin_p1) begin
                            // Repeated sample: the source simply has not advanced.
                            bin_p1 <= bin_p1;
`ifdef GRAY_DIR_DOWN_EN
                        end else if (d_p0 == p_dec) begin
                            bin_p1 <= d_p0;
                            if (bin_p1 == '0) begin
                                wrap_cnt <= sat_dec(wrap_cnt);
                            end
`endif
                        end else begin
                            step_err_p1 <= 1'b1;
                            err_sticky  <= 1'b1;
                            state       <= ST_FAULT;
                        end
                    end
                    default: begin
                        state <= state;
                    end
                endcase
            end
        end
    end

    assign bus.Bin        = bin_p1;
    assign bus.Bin_Valid  = bin_vld_p1;
    assign bus.Step_Err   = step_err_p1;
    assign bus.Err_Sticky = err_sticky;
    assign bus.Wrap_Cnt   = wrap_cnt;
    assign bus.Overflow   = overflow;
endmodule

// File: tb/tb_gray_tracker.sv
// Directed scoreboard bench for gray_tracker (WIDTH=3, CNT_W=4).
module tb_gray_tracker;
    logic Clk = 1'b0;
    logic Reset;
    always #5 Clk = ~Clk;

    gray_tracker_if #(.WIDTH(3), .CNT_W(4)) bus ();
    gray_tracker #(.WIDTH(3), .CNT_W(4)) dut (.Clk(Clk), .Reset(Reset), .bus(bus));

    typedef struct {
        logic [2:0] bin;
        logic       bv;
        logic       se;
        logic       es;
        logic [3:0] wc;
        logic       ov;
    } exp_t;

    exp_t q[$];
    int   cmps  = 0;
    int   fails = 0;

    // Reference model state
    int         m_st;   // 0 empty, 1 locked, 2 fault
    logic [2:0] m_bin;
    logic       m_bv, m_se, m_es, m_ov;
    logic [3:0] m_wc;

    function automatic logic [2:0] b2g(input int b);
        logic [2:0] v;
        v = 3'(b);
        return v ^ (v >> 1);
    endfunction

    function automatic logic [2:0] g2b(input logic [2:0] g);
        return g ^ (g >> 1) ^ (g >> 2);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        cmps++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model(input logic r, input logic v, input logic [2:0] g, input logic c);
        logic [2:0] d;
        exp_t e;
        d = g2b(g);
        if (r) begin
            m_st = 0; m_bin = 0; m_bv = 0; m_se = 0; m_es = 0; m_wc = 0; m_ov = 0;
        end else begin
            m_se = 0;
            if (c) begin
                m_st = 0; m_es = 0; m_bv = 0;
            end else if (v) begin
                if (m_st == 0) begin
                    m_bin = d; m_bv = 1; m_st = 1;
                end else if (m_st == 1) begin
                    if (d == 3'(m_bin + 3'd1)) begin
                        if (m_bin == 3'd7) begin
                            if (m_wc != 4'hf) m_wc = m_wc + 4'd1;
                            m_ov = 1;
                        end
                        m_bin = d;
                    end else if (d == m_bin) begin
                        m_bin = m_bin;
`ifdef GRAY_DIR_DOWN_EN
                    end else if (d == 3'(m_bin - 3'd1)) begin
                        if (m_bin == 3'd0 && m_wc != 4'h0) m_wc = m_wc - 4'd1;
                        m_bin = d;
`endif
                    end else begin
                        m_se = 1; m_es = 1; m_st = 2;
                    end
                end
            end
        end
        e.bin = m_bin; e.bv = m_bv; e.se = m_se; e.es = m_es; e.wc = m_wc; e.ov = m_ov;
        q.push_back(e);
    endtask

    task automatic apply(input logic r, input logic v, input logic [2:0] g, input logic c);
        exp_t e;
        @(negedge Clk);
        Reset = r; bus.Valid = v; bus.Gray = g; bus.Clear = c;
        model(r, v, g, c);
        @(posedge Clk);
        #1;
        if (q.size() == 0) begin
            cmps++; fails++;
            $error("FAIL scoreboard_empty observed=0 expected=1");
        end else begin
            e = q.pop_front();
            chk("Bin",        32'(bus.Bin),        32'(e.bin));
            chk("Bin_Valid",  32'(bus.Bin_Valid),  32'(e.bv));
            chk("Step_Err",   32'(bus.Step_Err),   32'(e.se));
            chk("Err_Sticky", 32'(bus.Err_Sticky), 32'(e.es));
            chk("Wrap_Cnt",   32'(bus.Wrap_Cnt),   32'(e.wc));
            chk("Overflow",   32'(bus.Overflow),   32'(e.ov));
        end
    endtask

    task automatic smp(input int b);
        apply(1'b0, 1'b1, b2g(b), 1'b0);
    endtask

    task automatic idle();
        apply(1'b0, 1'b0, 3'b000, 1'b0);
    endtask

    task automatic clr();
        apply(1'b0, 1'b0, 3'b000, 1'b1);
    endtask

    initial begin
        Reset = 1'b1; bus.Valid = 1'b0; bus.Gray = '0; bus.Clear = 1'b0;
        m_st = 0; m_bin = 0; m_bv = 0; m_se = 0; m_es = 0; m_wc = 0; m_ov = 0;

        // Reset state
        apply(1'b1, 1'b0, 3'b000, 1'b0);
        apply(1'b1, 1'b1, 3'b111, 1'b0);
        chk("reset_bin", 32'(bus.Bin), 32'd0);

        // Full forward cycle with one wrap
        for (int i = 0; i <= 8; i++) smp(i % 8);
        chk("fwd_wrap", 32'(bus.Wrap_Cnt), 32'd1);
        chk("fwd_ovf",  32'(bus.Overflow), 32'd1);
        idle();

        // Illegal jump, ignored sample in FAULT, recovery via Clear
        clr();
        apply(1'b0, 1'b1, 3'b001, 1'b0);
        apply(1'b0, 1'b1, 3'b010, 1'b0);
        chk("jump_err", 32'(bus.Step_Err), 32'd1);
        apply(1'b0, 1'b1, 3'b011, 1'b0);
        chk("fault_hold", 32'(bus.Bin), 32'd1);
        clr();
        apply(1'b0, 1'b1, 3'b110, 1'b0);
        chk("recover_bin", 32'(bus.Bin), 32'd4);

        // Repeat sample
        clr();
        apply(1'b0, 1'b1, 3'b011, 1'b0);
        apply(1'b0, 1'b1, 3'b011, 1'b0);
        chk("repeat_bin", 32'(bus.Bin), 32'd2);

        // Downward step, then downward wrap
        clr();
        apply(1'b0, 1'b1, 3'b011, 1'b0);
        apply(1'b0, 1'b1, 3'b001, 1'b0);
        apply(1'b0, 1'b1, 3'b000, 1'b0);
        apply(1'b0, 1'b1, 3'b100, 1'b0);
        idle();

        // Seventeen forward cycles saturate the wrap counter
        apply(1'b1, 1'b0, 3'b000, 1'b0);
        smp(0);
        for (int k = 1; k <= 136; k++) smp(k % 8);
        chk("sat_wrap", 32'(bus.Wrap_Cnt), 32'd15);
        smp(1);

        // Mid-stream reset with Valid high, then unchecked lock
        apply(1'b1, 1'b1, 3'b011, 1'b0);
        chk("midrst_ovf", 32'(bus.Overflow), 32'd0);
        apply(1'b0, 1'b1, 3'b101, 1'b0);
        apply(1'b0, 1'b1, 3'b100, 1'b0);

        // Clear and Valid on the same edge
        apply(1'b0, 1'b1, 3'b110, 1'b1);
        chk("clrvld_bv", 32'(bus.Bin_Valid), 32'd0);
        apply(1'b0, 1'b1, 3'b110, 1'b0);

        // Pseudo-random mix of steps, repeats, jumps and clears
        for (int n = 0; n < 40; n++) begin
            int r;
            r = int'($urandom_range(0, 9));
            if (r == 0) clr();
            else if (r == 1) idle();
            else if (r < 6) smp(int'(g2b(bus.Bin)) + 1);
            else if (r == 6) smp(int'(g2b(bus.Bin)) + 7);
            else smp(int'($urandom_range(0, 7)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", cmps, fails);
        $finish;
    end
endmodule
